key_debouncer: RTL

Conditions the raw board push-button before it reaches the CPU's `io_in[0]`. The block synchronises the asynchronous pin into the `clk` domain and filters contact bounce with a four-state debounce FSM. It then presents a clean level plus one-cycle press/release pulses. It sits between the `key` pad and the CPU I/O input in the top level, and runs on the undivided board clock.

---
 rtl/key_debouncer_pkg.sv | 18 +
 rtl/key_debouncer_sync_2ff.sv | 35 +++
 rtl/key_debouncer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/key_debouncer_pkg.sv
// ---------------------------------------------------------------------------
// key_debouncer_pkg
//   Shared types and constants for the push-button debouncer.
//   - deb_state_t : 2-bit debounce FSM state encoding
//   - SYNC_STAGES : number of flops in the pad synchroniser
// ---------------------------------------------------------------------------
package key_debouncer_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } deb_state_t;

  localparam int SYNC_STAGES = 2;

endpackage : key_debouncer_pkg

// File: rtl/key_debouncer_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//   Generic 1-bit two-flop synchroniser for asynchronous pad inputs.
//   Parameters:
//     RESET_VALUE : level both flops take while rst is high
//   Ports:
//     clk  in  destination clock
//     rst  in  synchronous, active-high reset
//     d    in  asynchronous input
//     q    out synchronised output (SYNC_STAGES cycles of latency)
// ---------------------------------------------------------------------------
module sync_2ff
  import key_debouncer_pkg::*;
#(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stage_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_reg <= {SYNC_STAGES{RESET_VALUE}};
    end else begin
      stage_reg <= {stage_reg[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stage_reg[SYNC_STAGES-1];

endmodule : sync_2ff

// File: rtl/key_debouncer.sv
// ---------------------------------------------------------------------------
// key_debouncer
//   Synchronises the raw push-button pin and filters contact bounce with a
//   four-state FSM, producing a clean level plus press/release strobes.
//
//   Optional feature macro: KEY_DEBOUNCER_LONG_PRESS_EN
//     defined   -> hold counter drives a one-shot long_press strobe
//     undefined -> long_press tied low, LONG_CYCLES has no effect
//
//   Parameters:
//     DEBOUNCE_CYCLES : stable samples needed to accept a change (>= 2)
//     ACTIVE_LOW      : 1 = pin low means pressed
//     LONG_CYCLES     : hold time for long_press (feature builds only)
//   Ports:
//     clk            in  board clock
//     rst            in  synchronous, active-high reset
//     key            in  raw asynchronous pin
//     pressed        out debounced level, 1 = held
//     press_pulse    out one-cycle strobe on accepted press
//     release_pulse  out one-cycle strobe on accepted release
//     long_press     out one-cycle strobe at long-press threshold
// ---------------------------------------------------------------------------
module key_debouncer
  import key_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int LONG_CYCLES     = 27000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  // The state-entry sample already counts as the first stable one, so the
  // counter only has to cover the remaining DEBOUNCE_CYCLES-1 samples.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic       key_norm;
  logic       key_s;
  deb_state_t state_reg;
  logic [CNT_W-1:0] cnt_reg;

  // Normalise polarity before the synchroniser so key_s is always 1 = pressed.
  assign key_norm = ACTIVE_LOW ? ~key : key;

  sync_2ff #(
    .RESET_VALUE (1'b0)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (key_norm),
    .q   (key_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= RELEASED;
      cnt_reg       <= '0;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state_reg)
        RELEASED: begin
          if (key_s) begin
            state_reg <= PRESS_PEND;
            cnt_reg   <= '0;
          end
        end
        PRESS_PEND: begin
          if (!key_s) begin
            state_reg <= RELEASED;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg   <= PRESSED;
            pressed     <= 1'b1;
            press_pulse <= 1'b1;
          end else if (cnt_reg != CNT_MAX) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        PRESSED: begin
          if (!key_s) begin
            state_reg <= RELEASE_PEND;
            cnt_reg   <= '0;
          end
        end
        RELEASE_PEND: begin
          // pressed stays 1 here: a release is not believed until it is stable.
          if (key_s) begin
            state_reg <= PRESSED;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg     <= RELEASED;
            pressed       <= 1'b0;
            release_pulse <= 1'b1;
          end else if (cnt_reg != CNT_MAX) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= RELEASED;
        end
      endcase
    end
  end

`ifdef KEY_DEBOUNCER_LONG_PRESS_EN
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

  logic [HOLD_W-1:0] hold_cnt_reg;
  logic              enter_pressed;

  // Same condition that raises press_pulse; only a fresh press restarts the
  // hold time, bounces that fall back from RELEASE_PEND do not.
  assign enter_pressed = (state_reg == PRESS_PEND) && key_s && (cnt_reg == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_reg <= '0;
      long_press   <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (enter_pressed) begin
        hold_cnt_reg <= '0;
      end else if (pressed && (hold_cnt_reg != HOLD_MAX)) begin
        hold_cnt_reg <= hold_cnt_reg + 1'b1;
        // Saturation at HOLD_MAX guarantees this fires only once per hold.
        long_press   <= (hold_cnt_reg == HOLD_MAX - 1'b1);
      end
    end
  end
`else
  // Always false; referencing LONG_CYCLES keeps the parameter visibly consumed.
  assign long_press = (LONG_CYCLES < 0);
`endif

endmodule : key_debouncer
